// File: rtl/blit_copy_engine_if.sv
// Blitter-port bus of the pattern memory: single-outstanding request/ack with
// word-aligned byte addresses.
interface blit_copy_engine_if #(
  parameter int ADDR_WIDTH = 16
);
  logic                  blit_request;
  logic [ADDR_WIDTH-1:0] blit_addr;
  logic                  blit_write;
  logic [3:0]            blit_byte_enable;
  logic [31:0]           blit_wdata;
  logic [31:0]           blit_rdata;
  logic                  blit_ack;

  modport master (
    output blit_request, blit_addr, blit_write, blit_byte_enable, blit_wdata,
    input  blit_rdata, blit_ack
  );

  modport slave (
    input  blit_request, blit_addr, blit_write, blit_byte_enable, blit_wdata,
    output blit_rdata, blit_ack
  );
endinterface

// File: rtl/blit_copy_engine.sv
// CPU-programmed word copy / word fill engine driving the pattern memory's
// blitter port, one transaction in flight at a time.
module blit_copy_engine #(
  parameter int ADDR_WIDTH  = 16,
  parameter int COUNT_WIDTH = 14
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   abort,
  input  logic                   mode_fill,
  input  logic [ADDR_WIDTH-1:0]  src_addr,
  input  logic [ADDR_WIDTH-1:0]  dst_addr,
  input  logic [COUNT_WIDTH-1:0] word_count,
  input  logic [31:0]            fill_value,
  output logic                   busy,
  output logic                   done,
  output logic                   aborted,
  blit_copy_engine_if.master     blit
);

  typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT, FINISH} state_t;

  state_t                 state_q, state_d;
  logic [ADDR_WIDTH-1:0]  src_q, src_d, dst_q, dst_d, addr_q, addr_d;
  logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [31:0]            fill_q, fill_d, wdata_q, wdata_d;
  logic                   mode_q, mode_d, req_q, req_d, write_q, write_d;
  logic                   busy_q, busy_d, done_q, done_d, aborted_q, aborted_d;
  logic [ADDR_WIDTH-1:0]  src_nx, dst_nx;

  function automatic logic [ADDR_WIDTH-1:0] word_align(input logic [ADDR_WIDTH-1:0] a);
    return {a[ADDR_WIDTH-1:2], 2'b00};
  endfunction

  // Pointer increments wrap naturally modulo 2^ADDR_WIDTH.
  assign src_nx = src_q + ADDR_WIDTH'(4);
  assign dst_nx = dst_q + ADDR_WIDTH'(4);

  always_comb begin
    state_d   = state_q;
    src_d     = src_q;
    dst_d     = dst_q;
    cnt_d     = cnt_q;
    fill_d    = fill_q;
    mode_d    = mode_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    write_d   = write_q;
    req_d     = 1'b0;
    busy_d    = busy_q;
    done_d    = 1'b0;
    aborted_d = aborted_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          src_d     = word_align(src_addr);
          dst_d     = word_align(dst_addr);
          cnt_d     = word_count;
          mode_d    = mode_fill;
          fill_d    = fill_value;
          aborted_d = 1'b0;
          busy_d    = 1'b1;
          if (word_count == '0) begin
            state_d = FINISH;
          end else if (mode_fill) begin
            state_d = WR_REQ;
            req_d   = 1'b1;
            write_d = 1'b1;
            addr_d  = word_align(dst_addr);
            wdata_d = fill_value;
          end else begin
            state_d = RD_REQ;
            req_d   = 1'b1;
            write_d = 1'b0;
            addr_d  = word_align(src_addr);
          end
        end
      end
      RD_REQ: state_d = RD_WAIT;
      RD_WAIT: begin
        if (blit.blit_ack) begin
          // The write data register doubles as the copy holding register.
          wdata_d = blit.blit_rdata;
          if (abort) begin
            state_d   = FINISH;
            done_d    = 1'b1;
            busy_d    = 1'b0;
            aborted_d = 1'b1;
          end else begin
            state_d = WR_REQ;
            req_d   = 1'b1;
            write_d = 1'b1;
            addr_d  = dst_q;
          end
        end
      end
      WR_REQ: state_d = WR_WAIT;
      WR_WAIT: begin
        if (blit.blit_ack) begin
          cnt_d = cnt_q - COUNT_WIDTH'(1);
          src_d = src_nx;
          dst_d = dst_nx;
          if (cnt_q == COUNT_WIDTH'(1) || abort) begin
            state_d   = FINISH;
            done_d    = 1'b1;
            busy_d    = 1'b0;
            aborted_d = (cnt_q != COUNT_WIDTH'(1));
          end else if (mode_q) begin
            state_d = WR_REQ;
            req_d   = 1'b1;
            write_d = 1'b1;
            addr_d  = dst_nx;
            wdata_d = fill_q;
          end else begin
            state_d = RD_REQ;
            req_d   = 1'b1;
            write_d = 1'b0;
            addr_d  = src_nx;
          end
        end
      end
      FINISH: begin
        // Arriving from IDLE (zero-length job) the done pulse is still owed.
        state_d = IDLE;
        if (busy_q) begin
          done_d = 1'b1;
          busy_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      src_q     <= '0;
      dst_q     <= '0;
      cnt_q     <= '0;
      fill_q    <= '0;
      mode_q    <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      write_q   <= 1'b0;
      req_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      src_q     <= src_d;
      dst_q     <= dst_d;
      cnt_q     <= cnt_d;
      fill_q    <= fill_d;
      mode_q    <= mode_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      write_q   <= write_d;
      req_q     <= req_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      aborted_q <= aborted_d;
    end
  end

  assign busy                  = busy_q;
  assign done                  = done_q;
  assign aborted               = aborted_q;
  assign blit.blit_request     = req_q;
  assign blit.blit_addr        = addr_q;
  assign blit.blit_write       = write_q;
  assign blit.blit_wdata       = wdata_q;
  assign blit.blit_byte_enable = 4'hF;

endmodule

// File: tb/tb_blit_copy_engine.sv
// Directed bench for blit_copy_engine with a latency-configurable memory
// responder that logs every completed read and write.
`timescale 1ns/1ps
module tb_blit_copy_engine;
  localparam int AW = 16;
  localparam int CW = 14;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          mode_fill = 1'b0;
  logic [AW-1:0] src_addr = '0;
  logic [AW-1:0] dst_addr = '0;
  logic [CW-1:0] word_count = '0;
  logic [31:0]   fill_value = '0;
  logic          busy, done, aborted;

  int errors = 0;
  int checks = 0;

  blit_copy_engine_if #(.ADDR_WIDTH(AW)) bus ();

  blit_copy_engine #(.ADDR_WIDTH(AW), .COUNT_WIDTH(CW)) dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .abort      (abort),
    .mode_fill  (mode_fill),
    .src_addr   (src_addr),
    .dst_addr   (dst_addr),
    .word_count (word_count),
    .fill_value (fill_value),
    .busy       (busy),
    .done       (done),
    .aborted    (aborted),
    .blit       (bus)
  );

  always #5 clock = ~clock;

  // Memory responder: reads return a pattern derived from the address.
  int            lat_fixed = 1;
  bit            lat_rand = 1'b0;
  bit            pend = 1'b0;
  int            left = 0;
  logic [AW-1:0] p_addr;
  logic          p_wr;
  logic [31:0]   p_wd;
  logic [AW-1:0] rd_a[$];
  logic [AW-1:0] wr_a[$];
  logic [31:0]   wr_d[$];

  function automatic logic [31:0] src_word(input logic [AW-1:0] a);
    return {16'hC0DE, a};
  endfunction

  always @(posedge clock) begin
    automatic int            l;
    automatic bit            fire;
    automatic logic [AW-1:0] fa;
    automatic logic          fw;
    automatic logic [31:0]   fd;
    fire = 1'b0;
    fa = '0;
    fw = 1'b0;
    fd = '0;
    bus.blit_ack <= 1'b0;
    if (pend) begin
      if (left <= 1) begin
        fire = 1'b1; fa = p_addr; fw = p_wr; fd = p_wd;
        pend <= 1'b0;
      end else begin
        left <= left - 1;
      end
    end else if (bus.blit_request) begin
      l = lat_rand ? int'($urandom_range(1, 5)) : lat_fixed;
      if (l <= 1) begin
        fire = 1'b1; fa = bus.blit_addr; fw = bus.blit_write; fd = bus.blit_wdata;
      end else begin
        pend   <= 1'b1;
        left   <= l - 1;
        p_addr <= bus.blit_addr;
        p_wr   <= bus.blit_write;
        p_wd   <= bus.blit_wdata;
      end
    end
    if (fire) begin
      bus.blit_ack <= 1'b1;
      if (fw) begin
        wr_a.push_back(fa);
        wr_d.push_back(fd);
      end else begin
        rd_a.push_back(fa);
        bus.blit_rdata <= src_word(fa);
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Launch a job and count negedges until done; 0 cycles means timeout.
  task automatic run_job(input logic mf, input logic [AW-1:0] s, input logic [AW-1:0] d,
                         input logic [CW-1:0] n, input logic [31:0] f,
                         output int cyc, output int busy_n, output int req_n);
    @(negedge clock);
    mode_fill = mf; src_addr = s; dst_addr = d; word_count = n; fill_value = f;
    start = 1'b1;
    cyc = 0; busy_n = 0; req_n = 0;
    for (int i = 1; i <= 400; i++) begin
      @(negedge clock);
      start = 1'b0;
      if (busy) busy_n++;
      if (bus.blit_request) req_n++;
      if (done) begin
        cyc = i;
        break;
      end
    end
  endtask

  initial begin
    int cyc, busy_n, req_n, bw, br, wn;
    bit got_done, bad_req, bad_done;

    repeat (2) @(negedge clock);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_aborted", aborted, 1'b0);
    chk("rst_req", bus.blit_request, 1'b0);
    chk("rst_write", bus.blit_write, 1'b0);
    chk("rst_addr", bus.blit_addr, 16'h0000);
    chk("rst_wdata", bus.blit_wdata, 32'h0);
    chk("rst_be", bus.blit_byte_enable, 4'hF);
    reset = 1'b0;

    // Copy 4 words, single-cycle ack.
    br = rd_a.size(); bw = wr_a.size();
    run_job(1'b0, 16'h0100, 16'h0200, 14'd4, 32'h0, cyc, busy_n, req_n);
    chk("copy_done_cycle", cyc, 17);
    chk("copy_busy_cycles", busy_n, 16);
    chk("copy_requests", req_n, 8);
    chk("copy_aborted", aborted, 1'b0);
    chk("copy_reads", rd_a.size() - br, 4);
    chk("copy_writes", wr_a.size() - bw, 4);
    for (int i = 0; i < 4; i++) begin
      chk("copy_rd_addr", rd_a[br + i], 16'h0100 + 16'(4 * i));
      chk("copy_wr_addr", wr_a[bw + i], 16'h0200 + 16'(4 * i));
      chk("copy_wr_data", wr_d[bw + i], src_word(16'h0100 + 16'(4 * i)));
    end

    // Zero-length job: no traffic, single busy cycle.
    run_job(1'b0, 16'h0300, 16'h0400, 14'd0, 32'h0, cyc, busy_n, req_n);
    chk("zero_done_cycle", cyc, 2);
    chk("zero_busy_cycles", busy_n, 1);
    chk("zero_requests", req_n, 0);

    // Source address wraps past the top of memory.
    br = rd_a.size(); bw = wr_a.size();
    run_job(1'b0, 16'hFFF8, 16'h1000, 14'd3, 32'h0, cyc, busy_n, req_n);
    chk("wrap_rd0", rd_a[br], 16'hFFF8);
    chk("wrap_rd1", rd_a[br + 1], 16'hFFFC);
    chk("wrap_rd2", rd_a[br + 2], 16'h0000);
    chk("wrap_wr2_data", wr_d[bw + 2], src_word(16'h0000));
    chk("wrap_wr2_addr", wr_a[bw + 2], 16'h1008);

    // Abort raised while the second write is outstanding, random latency.
    lat_rand = 1'b1;
    bw = wr_a.size();
    @(negedge clock);
    mode_fill = 1'b0; src_addr = 16'h2000; dst_addr = 16'h3000; word_count = 14'd8;
    start = 1'b1;
    wn = 0; got_done = 1'b0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clock);
      start = 1'b0;
      if (bus.blit_request && bus.blit_write) wn++;
      if (wn == 2) abort = 1'b1;
      if (done) begin
        got_done = 1'b1;
        chk("abort_flag_at_done", aborted, 1'b1);
        break;
      end
    end
    chk("abort_done_seen", got_done, 1'b1);
    chk("abort_writes", wr_a.size() - bw, 2);
    @(negedge clock);
    abort = 1'b0;
    chk("abort_flag_held", aborted, 1'b1);
    chk("abort_done_pulse", done, 1'b0);
    lat_rand = 1'b0;

    // Fill 3 words; the new start clears aborted.
    br = rd_a.size(); bw = wr_a.size();
    run_job(1'b1, 16'h0041, 16'h0042, 14'd3, 32'hDEADBEEF, cyc, busy_n, req_n);
    chk("fill_done_cycle", cyc, 7);
    chk("fill_aborted", aborted, 1'b0);
    chk("fill_reads", rd_a.size() - br, 0);
    chk("fill_writes", wr_a.size() - bw, 3);
    for (int i = 0; i < 3; i++) begin
      chk("fill_wr_addr", wr_a[bw + i], 16'h0040 + 16'(4 * i));
      chk("fill_wr_data", wr_d[bw + i], 32'hDEADBEEF);
    end

    // Reset while a read is outstanding; its late ack must be ignored.
    lat_fixed = 3;
    bw = wr_a.size();
    @(negedge clock);
    mode_fill = 1'b0; src_addr = 16'h0500; dst_addr = 16'h0600; word_count = 14'd4;
    start = 1'b1;
    got_done = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      start = 1'b0;
      if (bus.blit_request && !bus.blit_write) begin
        got_done = 1'b1;
        break;
      end
    end
    chk("rstmid_read_issued", got_done, 1'b1);
    @(posedge clock);
    #1 reset = 1'b1;
    @(negedge clock);
    chk("rstmid_busy", busy, 1'b0);
    chk("rstmid_req", bus.blit_request, 1'b0);
    chk("rstmid_addr", bus.blit_addr, 16'h0000);
    reset = 1'b0;
    bad_req = 1'b0; bad_done = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      if (bus.blit_request) bad_req = 1'b1;
      if (done) bad_done = 1'b1;
    end
    chk("rstmid_no_request", bad_req, 1'b0);
    chk("rstmid_no_done", bad_done, 1'b0);
    chk("rstmid_no_write", wr_a.size() - bw, 0);
    chk("rstmid_wdata", bus.blit_wdata, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
